// File: rtl/seq_contador_modulo_if.sv
// Command channel of the modulo-N counter sequencer.
// The master issues commands; the slave (controller) reports readiness.
interface seq_contador_modulo_if #(
    parameter int WIDTH = 3
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface : seq_contador_modulo_if

// File: rtl/seq_contador_modulo.sv
// Command-driven sequencer for a programmable modulo-N up-counter.
// Commands: LOAD_MOD, START (bounded or free-run), PAUSE toggle, STOP.
// All outputs come straight from flops; tc/done/err are one-cycle pulses.
module seq_contador_modulo #(
    parameter int WIDTH   = 3,
    parameter int DEF_MOD = 7,
    parameter int WCNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  clear_n,
    seq_contador_modulo_if.slave  cmd,
    output logic [WIDTH-1:0]      q,
    output logic                  running,
    output logic                  paused,
    output logic                  tc,
    output logic                  done,
    output logic                  err,
    output logic [WCNT_W-1:0]     wrap_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    localparam logic [WIDTH-1:0]  W_ZERO  = WIDTH'(0);
    localparam logic [WIDTH-1:0]  W_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]  W_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0]  W_DEF   = WIDTH'(DEF_MOD);
    localparam logic [WCNT_W-1:0] C_ZERO  = WCNT_W'(0);
    localparam logic [WCNT_W-1:0] C_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] C_FULL  = {WCNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               ready_q;
    logic               run_q, run_d;
    logic               hold_q, hold_d;
    logic               tc_q, tc_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept_s;
    logic               at_top_s;

    // A command is taken only when the controller advertises ready.
    assign accept_s = cmd.cmd_valid && ready_q;
    // Last count value before the wrap back to zero.
    assign at_top_s = (q_q == (mod_q - W_ONE));

    // Next-state computation: accepted commands take priority over counting.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mod_d   = mod_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        tc_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (accept_s) begin
            case (cmd.cmd_op)
                OP_LOAD: begin
                    // Modulus may only change while idle, and must be >= 2.
                    if ((state_q == ST_IDLE) && (cmd.cmd_arg >= W_TWO)) begin
                        mod_d = cmd.cmd_arg;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_START: begin
                    // START restarts from any state, including a live run.
                    q_d     = W_ZERO;
                    rem_d   = cmd.cmd_arg;
                    wcnt_d  = C_ZERO;
                    state_d = ST_RUN;
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_HOLD;
                    end else if (state_q == ST_HOLD) begin
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STOP: begin
                    // STOP while idle is a silent no-op.
                    if (state_q != ST_IDLE) begin
                        q_d     = W_ZERO;
                        rem_d   = W_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end else if (state_q == ST_RUN) begin
            if (at_top_s) begin
                q_d  = W_ZERO;
                tc_d = 1'b1;
                if (wcnt_q != C_FULL) begin
                    wcnt_d = wcnt_q + C_ONE;
                end else begin
                    wcnt_d = wcnt_q;
                end
                // Bounded run: the wrap that exhausts the budget ends the run.
                if (rem_q != W_ZERO) begin
                    rem_d = rem_q - W_ONE;
                    if (rem_q == W_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    rem_d = rem_q;
                end
            end else begin
                q_d = q_q + W_ONE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Status flags are decoded from the next state so they leave a flop.
    always_comb begin
        run_d  = (state_d == ST_RUN);
        hold_d = (state_d == ST_HOLD);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            q_q     <= W_ZERO;
            mod_q   <= W_DEF;
            rem_q   <= W_ZERO;
            wcnt_q  <= C_ZERO;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
            hold_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mod_q   <= mod_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            ready_q <= 1'b1;
            run_q   <= run_d;
            hold_q  <= hold_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign q             = q_q;
    assign running       = run_q;
    assign paused        = hold_q;
    assign tc            = tc_q;
    assign done          = done_q;
    assign err           = err_q;
    assign wrap_cnt      = wcnt_q;

endmodule : seq_contador_modulo

// File: tb/tb_seq_contador_modulo.sv
// Scoreboard bench for seq_contador_modulo: stimulus pushes the model's
// expected outputs, an independent monitor pops and compares after each edge.
module tb_seq_contador_modulo;

    localparam int WIDTH = 3;
    localparam int WCNT_W = 8;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    logic clk = 1'b0;
    logic clear_n;
    logic [WIDTH-1:0]  q;
    logic              running, paused, tc, done, err;
    logic [WCNT_W-1:0] wrap_cnt;

    seq_contador_modulo_if #(.WIDTH(WIDTH)) cmd_if ();

    seq_contador_modulo #(.WIDTH(WIDTH), .DEF_MOD(7), .WCNT_W(WCNT_W)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .cmd      (cmd_if.slave),
        .q        (q),
        .running  (running),
        .paused   (paused),
        .tc       (tc),
        .done     (done),
        .err      (err),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] q;
        logic       running;
        logic       paused;
        logic       tc;
        logic       done;
        logic       err;
        logic       ready;
        logic [7:0] wcnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 counting, 2 held.
    int m_mode, m_count, m_mod, m_rem, m_wraps;
    bit m_ready;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_mod = 7; m_rem = 0; m_wraps = 0; m_ready = 0;
    endtask

    // Drive one cycle of stimulus now and push what the outputs must become.
    task automatic step_now(input bit v, input logic [1:0] op, input int a);
        exp_t e;
        bit etc, edone, eerr;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = a[2:0];
        etc = 0; edone = 0; eerr = 0;
        if (v && m_ready) begin
            if (op == LOAD) begin
                if (m_mode == 0 && a >= 2) m_mod = a; else eerr = 1;
            end else if (op == START) begin
                m_count = 0; m_rem = a; m_wraps = 0; m_mode = 1;
            end else if (op == PAUSE) begin
                if (m_mode == 0) eerr = 1; else m_mode = 3 - m_mode;
            end else begin
                if (m_mode != 0) begin m_count = 0; m_mode = 0; end
            end
        end else if (m_mode == 1) begin
            m_count = (m_count + 1) % m_mod;
            if (m_count == 0) begin
                etc = 1;
                if (m_wraps < 255) m_wraps++;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 0; edone = 1; end
                end
            end
        end
        m_ready = 1;
        e.q = m_count[2:0];
        e.running = (m_mode == 1);
        e.paused  = (m_mode == 2);
        e.tc = etc; e.done = edone; e.err = eerr;
        e.ready = 1'b1;
        e.wcnt = m_wraps[7:0];
        sbq.push_back(e);
    endtask

    task automatic step(input bit v, input logic [1:0] op, input int a);
        @(negedge clk);
        step_now(v, op, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, LOAD, 0);
    endtask

    // Monitor: compare every registered output shortly after each edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("q",        {29'd0, q},        {29'd0, e.q});
                check("running",  {31'd0, running},  {31'd0, e.running});
                check("paused",   {31'd0, paused},   {31'd0, e.paused});
                check("tc",       {31'd0, tc},       {31'd0, e.tc});
                check("done",     {31'd0, done},     {31'd0, e.done});
                check("err",      {31'd0, err},      {31'd0, e.err});
                check("ready",    {31'd0, cmd_if.cmd_ready}, {31'd0, e.ready});
                check("wrap_cnt", {24'd0, wrap_cnt}, {24'd0, e.wcnt});
            end
        end
    end

    initial begin : stim
        int guard;
        clear_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'b00;
        cmd_if.cmd_arg = 3'd0;
        model_reset();
        #2;
        check("rst_q",     {29'd0, q}, 32'd0);
        check("rst_run",   {31'd0, running}, 32'd0);
        check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        check("rst_wcnt",  {24'd0, wrap_cnt}, 32'd0);

        // Release; a START on the first edge is not accepted (ready still 0).
        @(negedge clk);
        clear_n = 1'b1;
        step_now(1, START, 0);

        // Free run with default modulus 7.
        step(1, START, 0);
        idle(15);
        step(1, STOP, 0);

        // Bounded run: modulus 5, two wraps.
        step(1, LOAD, 5);
        step(1, START, 2);
        idle(12);

        // Pause at q==3, hold 4 cycles, resume.
        step(1, LOAD, 7);
        step(1, START, 0);
        guard = 0;
        while (m_count != 3 && guard < 20) begin step(0, LOAD, 0); guard++; end
        step(1, PAUSE, 0);
        idle(4);
        step(1, PAUSE, 0);
        idle(4);
        step(1, STOP, 0);

        // Illegal commands: modulus must stay 7.
        step(1, LOAD, 1);
        step(1, START, 0);
        step(1, LOAD, 6);
        step(1, STOP, 0);
        step(1, PAUSE, 0);
        step(1, LOAD, 0);
        step(1, START, 0);
        idle(8);

        // STOP exactly at q==6.
        guard = 0;
        while (m_count != 6 && guard < 20) begin step(0, LOAD, 0); guard++; end
        step(1, STOP, 0);
        idle(2);

        // Back-to-back errors and START from HOLD.
        step(1, PAUSE, 0);
        step(1, PAUSE, 0);
        step(1, START, 1);
        step(1, PAUSE, 0);
        step(1, START, 1);
        idle(9);

        // Asynchronous clear mid-count at q==4.
        step(1, START, 0);
        guard = 0;
        while (m_count != 4 && guard < 20) begin step(0, LOAD, 0); guard++; end
        @(posedge clk);
        #3;
        clear_n = 1'b0;
        #1;
        check("async_q",     {29'd0, q}, 32'd0);
        check("async_run",   {31'd0, running}, 32'd0);
        check("async_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        step_now(0, LOAD, 0);

        // Modulus 2 and saturation of the wrap counter.
        step(1, LOAD, 2);
        step(1, START, 0);
        idle(520);
        step(1, STOP, 0);

        // Randomised commands.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 25)
                step(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            else
                step(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end
        cmd_if.cmd_valid = 1'b0;

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        #2;
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_contador_modulo

// File: doc/seq_contador_modulo.md
Name: seq_contador_modulo

Overview:
- Command-driven controller that sequences a programmable modulo-N up-counter for the sequential-logic lab designs.
- Accepts load-modulus, start, pause/resume and stop commands over a valid/ready interface.
- Runs the count either free-running or for a fixed number of wraps.
- Emits terminal-count, done and error pulses for the surrounding datapath.

Parameters:
- WIDTH, 3, counter and argument width in bits.
- DEF_MOD, 7, modulus after reset. Legal range is 2..2^WIDTH-1.
- WCNT_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  single clock. All state changes on its rising edge.
- clear_n  input  1  asynchronous, active-low reset (clear). Forces all state to reset values immediately.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  opcode: 00 LOAD_MOD, 01 START, 10 PAUSE (toggle), 11 STOP.
- cmd_arg  input  WIDTH  LOAD_MOD: new modulus. START: number of wraps, where 0 means free-run.
- q  output  WIDTH  current count, 0..mod-1.
- running  output  1  state is RUN.
- paused  output  1  state is HOLD.
- tc  output  1  one-cycle pulse on the edge where q wraps from mod-1 to 0.
- done  output  1  one-cycle pulse when a bounded run completes.
- err  output  1  one-cycle pulse when an illegal command is accepted.
- wrap_cnt  output  WCNT_W  wraps since last START. Saturates at all-ones.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - state=IDLE, q=0, mod_r=DEF_MOD, remaining=0, wrap_cnt=0.
  - tc=done=err=0, running=paused=0, cmd_ready=0.
- cmd_ready goes to 1 on the first rising edge after clear_n is released and stays 1 thereafter.
- A command is accepted on a rising edge where cmd_valid && cmd_ready. Its effects are visible on registered outputs after that same edge (latency 1).
- States and transitions:
  - IDLE:
    - LOAD_MOD with arg>=2 sets mod_r=arg. LOAD_MOD with arg 0 or 1 pulses err; mod_r is unchanged.
    - START: q=0, remaining=arg, wrap_cnt=0, go to RUN.
    - PAUSE: pulses err.
    - STOP: no-op, no err.
  - RUN:
    - Each edge with no accepted command: q = (q==mod_r-1) ? 0 : q+1.
    - On the wrap edge: tc=1 and wrap_cnt+1 (saturating).
    - If remaining!=0 on a wrap: remaining-1. When remaining reaches 0 on that wrap, go to IDLE with q=0 and pulse done in the same cycle as tc.
    - PAUSE: go to HOLD; q does not advance on that edge.
    - STOP: q=0, go to IDLE; no tc, no done.
    - START: restart with q=0, remaining=arg, wrap_cnt=0; stay in RUN.
    - LOAD_MOD: pulses err; ignored.
  - HOLD:
    - q is frozen.
    - PAUSE: go to RUN; counting resumes on the next edge.
    - STOP: q=0, go to IDLE.
    - START: same as the START action in RUN.
    - LOAD_MOD: pulses err.
- Priority: an accepted command overrides the count advance on that edge. No tc/done is produced on an edge consumed by a command, even when q==mod_r-1.
- Arithmetic:
  - q compare and increment are WIDTH bits; mod_r is WIDTH bits.
  - remaining is WIDTH bits.
  - wrap_cnt never wraps around.
- Pulse outputs (tc, done, err) are high for exactly one cycle per event. Back-to-back events give consecutive pulses.
- With mod_r=2, q alternates 0,1 and tc fires every second RUN edge.
- Reset asserted mid-run abandons the run immediately. No done is produced.

Test Plan:
- Reset then START arg=0 with default mod 7 -> q runs 0,1..6,0. tc high exactly on the 6->0 edge. wrap_cnt=1 after 7 RUN edges. done never fires.
- LOAD_MOD 5 in IDLE, then START arg=2 -> q 0..4,0..4,0. tc pulses twice. done coincides with the second tc. State returns to IDLE with q=0, running=0.
- START arg=0, PAUSE at q=3, idle 4 cycles, PAUSE -> q holds 3 with paused=1 for 4 cycles, then continues 4,5,6.
- LOAD_MOD 1 in IDLE, then LOAD_MOD 6 during RUN, then PAUSE in IDLE -> err pulses 3 times and mod_r stays 7.
- STOP accepted on the edge where q==6 in RUN -> q=0, IDLE, tc=0, done=0.
- clear_n driven low mid-count at q=4 -> q=0, running=0, cmd_ready=0 immediately without a clock edge. After release, cmd_ready=1 one edge later.
